// File: rtl/ins_mem_loader.sv
// ins_mem_loader: streams bytes into big-endian 32-bit words and writes them
// to instruction memory while holding the CPU off; flags writes past MEM_BYTES.
`default_nettype none

module ins_mem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int LEN_W     = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] word_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       byte_idx;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      base_q;
  logic [31:0]      data_q;
  logic             err_q;

  logic [LEN_W:0]   cnt_inc;
  logic [33:0]      start_last;
  logic [33:0]      next_last;
  logic [33:0]      mem_limit;

  // Overflow checks use 34-bit sums so they happen before any 32-bit wrap.
  assign cnt_inc    = {1'b0, word_cnt} + (LEN_W+1)'(1);
  assign mem_limit  = 34'(MEM_BYTES);
  assign start_last = 34'(base_addr) + 34'd3;
  assign next_last  = 34'(base_q) + 34'({cnt_inc, 2'b00}) + 34'd3;

  assign byte_ready = (state == RECV);
  assign wr_en      = (state == WRITE);
  assign cpu_hold   = (state != IDLE);
  assign done       = (state == FIN);
  assign err        = err_q;
  assign wr_data    = data_q;
  assign wr_addr    = base_q + 32'({word_cnt, 2'b00});

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      word_cnt <= '0;
      len_q    <= '0;
      base_q   <= 32'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= word_len;
            err_q    <= 1'b0;
            byte_idx <= 2'd0;
            word_cnt <= '0;
            if (word_len == '0) begin
              state <= FIN;
            end else if (start_last >= mem_limit) begin
              err_q <= 1'b1;
              state <= FIN;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (byte_valid) begin
            case (byte_idx)
              2'd0:    data_q[31:24] <= byte_in;
              2'd1:    data_q[23:16] <= byte_in;
              2'd2:    data_q[15:8]  <= byte_in;
              default: data_q[7:0]   <= byte_in;
            endcase
            // The index parks at 3 and only returns to 0 through WRITE.
            if (byte_idx == 2'd3) begin
              state <= WRITE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          word_cnt <= cnt_inc[LEN_W-1:0];
          byte_idx <= 2'd0;
          if (cnt_inc == {1'b0, len_q}) begin
            state <= FIN;
          end else if (next_last >= mem_limit) begin
            err_q <= 1'b1;
            state <= FIN;
          end else begin
            state <= RECV;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: scoreboard bench for ins_mem_loader sessions.
`default_nettype none

module tb_ins_mem_loader;

  localparam int LEN_W = 6;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = 32'd0;
  logic [LEN_W-1:0] word_len = '0;
  logic [7:0]       byte_in = 8'd0;
  logic             byte_valid = 1'b0;
  logic             byte_ready, wr_en, cpu_hold, done, err;
  logic [31:0]      wr_addr, wr_data;

  ins_mem_loader #(.MEM_BYTES(128), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .base_addr(base_addr),
    .word_len(word_len), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int cyc = 0;
  int wr_cnt, done_cnt, rdy_cnt, drops;
  int wr_cyc, done_cyc, start_cyc, last_acc_cyc;
  bit in_sess = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge CLK) begin
    if (Reset) begin
      if (wr_en) begin
        wr_cnt++;
        wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[63:32]));
          check("wr_data", 64'(wr_data), 64'(e[31:0]));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (byte_ready) rdy_cnt++;
      if (in_sess && !cpu_hold) drops++;
    end
  end

  task automatic pulse_start(input logic [31:0] base, input int len);
    start = 1'b1;
    base_addr = base;
    word_len = LEN_W'(len);
    @(posedge CLK); #1;
    start = 1'b0;
    start_cyc = cyc;
    in_sess = 1'b1;
    base_addr = $urandom;
    word_len = LEN_W'($urandom);
  endtask

  task automatic feed(input logic [7:0] bytes[$], input bit stall, input bit glitch);
    int i = 0;
    int guard = 0;
    bit g_done = 1'b0;
    bit acc;
    while (i < bytes.size() && guard < 2000) begin
      if (glitch && i == 2 && !g_done) begin
        start = 1'b1;
        base_addr = 32'h0;
        word_len = LEN_W'(1);
        byte_valid = 1'b0;
        g_done = 1'b1;
      end else begin
        start = 1'b0;
        byte_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        byte_in = bytes[i];
      end
      @(negedge CLK);
      acc = byte_ready && byte_valid;
      if (acc) last_acc_cyc = cyc;
      @(posedge CLK); #1;
      if (acc) i++;
      guard++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    check("feed_timeout", 64'(i), 64'(bytes.size()));
  endtask

  task automatic run_session(input logic [31:0] base, input int len, input int nwr,
                             input bit stall, input bit glitch, input bit exp_err,
                             input bit fixed_word);
    logic [7:0] bytes[$];
    logic [31:0] w;
    int k;
    for (int n = 0; n < nwr; n++) begin
      w = fixed_word ? 32'h8C010004 : $urandom;
      exp_q.push_back({base + 32'(4 * n), w});
      for (int b = 3; b >= 0; b--) bytes.push_back(w[8*b +: 8]);
    end
    wr_cnt = 0; done_cnt = 0; rdy_cnt = 0; drops = 0;
    pulse_start(base, len);
    feed(bytes, stall, glitch);
    k = 0;
    while (done_cnt == 0 && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    in_sess = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("done_count", 64'(done_cnt), 64'd1);
    check("err", 64'(err), 64'(exp_err));
    check("wr_count", 64'(wr_cnt), 64'(nwr));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("hold_drop", 64'(drops), 64'd0);
    if (nwr == 0) begin
      // No write: FIN is the state right after the start edge.
      check("done_direct", 64'(done_cyc - start_cyc), 64'd0);
      check("ready_never", 64'(rdy_cnt), 64'd0);
    end else begin
      check("wr_latency", 64'(wr_cyc - last_acc_cyc), 64'd1);
      if (!exp_err) check("done_after_wr", 64'(done_cyc - wr_cyc), 64'd1);
    end
  endtask

  initial begin
    logic [7:0] part[$];
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;

    run_session(32'h00, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);   // single word 0x8C010004
    run_session(32'h10, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0);   // stalls
    run_session(32'h78, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0);   // overflow on third word
    run_session(32'h00, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // zero length, clears err
    run_session(32'h80, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);   // overflow at start
    run_session(32'h40, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0);   // start ignored in RECV
    run_session(32'h04, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);   // clears err, back-to-back

    // Reset after two bytes of the first word.
    part.push_back(8'hAA);
    part.push_back(8'hBB);
    pulse_start(32'h20, 2);
    feed(part, 1'b0, 1'b0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    in_sess = 1'b0;
    check("mid_rst_ready", 64'(byte_ready), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    run_session(32'h00, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1);
  end

endmodule

`default_nettype wire
